// File: rtl/prco_alu_sched.sv
// rtl/prco_alu_sched.sv - issue/writeback sequencer around prco_alu
// Accepts one decoded instruction, pulses the ALU, then runs writeback, RAM access or branch flush.
module prco_alu_sched #(
  parameter int FLUSH_CYCLES = 2,
  parameter int RAM_TIMEOUT  = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dec_valid,
  output logic        q_dec_ready,
  input  logic [4:0]  i_dec_op,
  input  logic [2:0]  i_dec_rd,
  input  logic        i_dec_req_ram,
  output logic        q_alu_ce,
  output logic        q_alu_req_ram,
  input  logic        i_alu_ce_reg,
  input  logic        i_alu_ce_ram,
  input  logic        i_alu_branch,
  output logic        q_ram_req,
  output logic        q_ram_we,
  input  logic        i_ram_ack,
  output logic        q_reg_we,
  output logic [2:0]  q_reg_rd,
  output logic        q_wb_sel_ram,
  output logic        q_pc_load,
  output logic        q_flush,
  output logic        q_err_timeout,
  output logic [15:0] q_retired
);

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_MOV   = 5'd1;
  localparam logic [4:0] OP_MOVI  = 5'd2;
  localparam logic [4:0] OP_ADD   = 5'd3;
  localparam logic [4:0] OP_ADDI  = 5'd4;
  localparam logic [4:0] OP_SUBI  = 5'd5;
  localparam logic [4:0] OP_CMP   = 5'd6;
  localparam logic [4:0] OP_SET   = 5'd7;
  localparam logic [4:0] OP_JMP   = 5'd8;
  localparam logic [4:0] OP_LW    = 5'd9;
  localparam logic [4:0] OP_SW    = 5'd10;
  localparam logic [4:0] OP_READ  = 5'd11;
  localparam logic [4:0] OP_WRITE = 5'd12;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_RAM   = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  localparam logic [7:0] RAM_LAST   = 8'(RAM_TIMEOUT - 1);
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [2:0]  rd_q, rd_d;
  logic        req_ram_q, req_ram_d;
  logic        alu_ce_q, alu_ce_d;
  logic        sel_ram_q, sel_ram_d;
  logic [7:0]  ram_cnt_q, ram_cnt_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic        err_q, err_d;
  logic [15:0] retired_q, retired_d;
  logic        op_writes;
  logic        retire;

  always_comb begin
    op_writes = 1'b0;
    case (op_q)
      OP_MOV, OP_MOVI, OP_ADD, OP_ADDI, OP_SUBI, OP_SET, OP_READ: op_writes = 1'b1;
      default: op_writes = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    req_ram_d   = req_ram_q;
    alu_ce_d    = 1'b0;
    sel_ram_d   = sel_ram_q;
    ram_cnt_d   = ram_cnt_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q;
    retire      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_dec_valid) begin
          op_d      = i_dec_op;
          rd_d      = i_dec_rd;
          req_ram_d = i_dec_req_ram;
          alu_ce_d  = 1'b1;
          sel_ram_d = 1'b0;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        // A taken branch wins over any memory or register strobe raised alongside it.
        if (i_alu_branch) begin
          flush_cnt_d = 4'd0;
          retire      = 1'b1;
          state_d     = S_FLUSH;
        end else if (i_alu_ce_ram) begin
          ram_cnt_d = 8'd0;
          state_d   = S_RAM;
        end else if (i_alu_ce_reg) begin
          if (op_writes) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RAM: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds.
        if (i_ram_ack) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_IDLE;
          end else begin
            sel_ram_d = 1'b1;
            state_d   = S_WB;
          end
        end else if (ram_cnt_q == RAM_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          ram_cnt_d = ram_cnt_q + 8'd1;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    retired_d = retired_q + {15'd0, retire};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      op_q        <= 5'd0;
      rd_q        <= 3'd0;
      req_ram_q   <= 1'b0;
      alu_ce_q    <= 1'b0;
      sel_ram_q   <= 1'b0;
      ram_cnt_q   <= 8'd0;
      flush_cnt_q <= 4'd0;
      err_q       <= 1'b0;
      retired_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      req_ram_q   <= req_ram_d;
      alu_ce_q    <= alu_ce_d;
      sel_ram_q   <= sel_ram_d;
      ram_cnt_q   <= ram_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
      retired_q   <= retired_d;
    end
  end

  // Strobes decode straight from state flops, so reset silences them on the next cycle.
  assign q_dec_ready   = (state_q == S_IDLE);
  assign q_alu_ce      = alu_ce_q;
  assign q_alu_req_ram = req_ram_q;
  assign q_ram_req     = (state_q == S_RAM);
  assign q_ram_we      = q_ram_req && (op_q == OP_SW);
  assign q_reg_we      = (state_q == S_WB);
  assign q_reg_rd      = q_reg_we ? rd_q : 3'd0;
  assign q_wb_sel_ram  = q_reg_we && sel_ram_q;
  assign q_flush       = (state_q == S_FLUSH);
  assign q_pc_load     = q_flush && (flush_cnt_q == 4'd0);
  assign q_err_timeout = err_q;
  assign q_retired     = retired_q;

endmodule

// File: tb/tb_prco_alu_sched.sv
// tb/tb_prco_alu_sched.sv - self-checking bench for prco_alu_sched
// Each instruction's expected output timeline is built from per-class latency rules.
module tb_prco_alu_sched;

  localparam int FLUSH = 2;
  localparam int TO    = 8;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_MOV   = 5'd1;
  localparam logic [4:0] OP_MOVI  = 5'd2;
  localparam logic [4:0] OP_ADD   = 5'd3;
  localparam logic [4:0] OP_ADDI  = 5'd4;
  localparam logic [4:0] OP_SUBI  = 5'd5;
  localparam logic [4:0] OP_CMP   = 5'd6;
  localparam logic [4:0] OP_SET   = 5'd7;
  localparam logic [4:0] OP_JMP   = 5'd8;
  localparam logic [4:0] OP_LW    = 5'd9;
  localparam logic [4:0] OP_SW    = 5'd10;
  localparam logic [4:0] OP_READ  = 5'd11;
  localparam logic [4:0] OP_WRITE = 5'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_op;
  logic [2:0]  dec_rd;
  logic        dec_req_ram;
  logic        alu_ce, alu_req_ram;
  logic        alu_ce_reg, alu_ce_ram, alu_branch;
  logic        ram_req, ram_we, ram_ack;
  logic        reg_we;
  logic [2:0]  reg_rd;
  logic        wb_sel_ram, pc_load, flush, err_timeout;
  logic [15:0] retired;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_retired;
  logic        model_err;

  always #5 clk = ~clk;

  prco_alu_sched #(.FLUSH_CYCLES(FLUSH), .RAM_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_dec_valid(dec_valid), .q_dec_ready(dec_ready),
    .i_dec_op(dec_op), .i_dec_rd(dec_rd), .i_dec_req_ram(dec_req_ram),
    .q_alu_ce(alu_ce), .q_alu_req_ram(alu_req_ram),
    .i_alu_ce_reg(alu_ce_reg), .i_alu_ce_ram(alu_ce_ram), .i_alu_branch(alu_branch),
    .q_ram_req(ram_req), .q_ram_we(ram_we), .i_ram_ack(ram_ack),
    .q_reg_we(reg_we), .q_reg_rd(reg_rd), .q_wb_sel_ram(wb_sel_ram),
    .q_pc_load(pc_load), .q_flush(flush),
    .q_err_timeout(err_timeout), .q_retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // 0: retire without writeback, 1: register writeback, 2: taken branch, 3: RAM access
  function automatic int op_class(input logic [4:0] op, input bit taken);
    case (op)
      OP_MOV, OP_MOVI, OP_ADD, OP_ADDI, OP_SUBI, OP_SET, OP_READ: return 1;
      OP_LW, OP_SW: return 3;
      OP_JMP: return taken ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int last_cycle(input int cls, input int s, input int a, input bit sw);
    case (cls)
      0: return s + 1;
      1: return s + 2;
      2: return s + 1 + FLUSH;
      default: return (a == 0) ? s + TO + 1 : (sw ? s + a + 1 : s + a + 2);
    endcase
  endfunction

  function automatic logic [10:0] exp_vec(input int k, input int cls, input int s, input int a,
                                          input bit sw, input logic [2:0] rd);
    int   last = last_cycle(cls, s, a, sw);
    int   rend = (a == 0) ? TO : a;
    logic rdy, ce, req, we, rwe, sel, pcl, fl;
    logic [2:0] r;
    rdy = (k == last);
    ce  = (k == 1);
    req = (cls == 3) && (k >= s + 1) && (k <= s + rend);
    we  = req && sw;
    rwe = (cls == 1 && k == s + 1) || (cls == 3 && !sw && a != 0 && k == s + a + 1);
    r   = rwe ? rd : 3'd0;
    sel = rwe && (cls == 3);
    pcl = (cls == 2) && (k == s + 1);
    fl  = (cls == 2) && (k >= s + 1) && (k <= s + FLUSH);
    return {rdy, ce, req, we, rwe, r, sel, pcl, fl};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of its next ready cycle.
  task automatic run_instr(input logic [4:0] op, input logic [2:0] rd, input int dly, input int a,
                           input bit taken, input bit hold_valid, input bit extra_reg);
    int          cls  = op_class(op, taken);
    int          s    = 2 + dly;
    bit          sw   = (op == OP_SW);
    int          last = last_cycle(cls, s, a, sw);
    logic [10:0] obs;
    dec_valid   = 1'b1;
    dec_op      = op;
    dec_rd      = rd;
    dec_req_ram = (cls == 3);
    alu_ce_reg  = 1'b0;
    alu_ce_ram  = 1'b0;
    alu_branch  = 1'b0;
    ram_ack     = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      obs = {dec_ready, alu_ce, ram_req, ram_req & ram_we, reg_we,
             reg_we ? reg_rd : 3'd0, reg_we & wb_sel_ram, pc_load, flush};
      check($sformatf("op%0d_rd%0d_cyc%0d", op, rd, k), 32'(obs), 32'(exp_vec(k, cls, s, a, sw, rd)));
      if (k == 1) check("alu_req_ram", 32'(alu_req_ram), 32'(cls == 3));
      alu_ce_reg = (k == s) && (cls != 3 || extra_reg);
      alu_ce_ram = (k == s) && (cls == 3);
      alu_branch = (k == s) && (cls == 2);
      ram_ack    = (cls == 3) && (a != 0) && (k == s + a);
      dec_valid  = (k < last) ? hold_valid : 1'b0;
      if (hold_valid) begin
        dec_op      = 5'($urandom);
        dec_rd      = 3'($urandom);
        dec_req_ram = 1'($urandom);
      end
    end
    if (cls == 3 && a == 0) model_err = 1'b1;
    else model_retired = model_retired + 16'd1;
    check("retired", 32'(retired), 32'(model_retired));
    check("err_timeout", 32'(err_timeout), 32'(model_err));
  endtask

  logic [4:0] ops [13];

  initial begin
    ops = '{OP_NOP, OP_MOV, OP_MOVI, OP_ADD, OP_ADDI, OP_SUBI, OP_CMP,
            OP_SET, OP_JMP, OP_LW, OP_SW, OP_READ, OP_WRITE};
    reset = 1'b1; dec_valid = 1'b0; dec_op = 5'd0; dec_rd = 3'd0; dec_req_ram = 1'b0;
    alu_ce_reg = 1'b0; alu_ce_ram = 1'b0; alu_branch = 1'b0; ram_ack = 1'b0;
    model_retired = 16'd0; model_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({dec_ready, alu_ce, ram_req, ram_we, reg_we, reg_rd,
                                wb_sel_ram, pc_load, flush, err_timeout}), 32'(12'h800));
    check("reset_retired", 32'(retired), 32'd0);
    reset = 1'b0;

    run_instr(OP_ADD, 3'd3, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_LW,  3'd5, 0, 4, 1'b0, 1'b0, 1'b0);
    run_instr(OP_SW,  3'd1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_JMP, 3'd2, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(OP_JMP, 3'd4, 1, 0, 1'b0, 1'b1, 1'b0);
    run_instr(OP_LW,  3'd7, 0, TO, 1'b0, 1'b1, 1'b1);
    run_instr(OP_SW,  3'd0, 2, 1, 1'b0, 1'b0, 1'b1);
    run_instr(OP_ADDI, 3'd6, 0, 0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      int         a;
      op = ops[$urandom_range(0, 12)];
      a  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
      run_instr(op, 3'($urandom), $urandom_range(0, 2), a, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a RAM wait
    dec_valid = 1'b1; dec_op = OP_LW; dec_rd = 3'd2; dec_req_ram = 1'b1;
    @(negedge clk); dec_valid = 1'b0;
    @(negedge clk); alu_ce_ram = 1'b1;
    @(negedge clk); alu_ce_ram = 1'b0;
    check("ram_wait_req", 32'(ram_req), 32'd1);
    @(negedge clk);
    check("ram_wait_req2", 32'(ram_req), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midreset_out%0d", i), 32'({dec_ready, alu_ce, ram_req, ram_we, reg_we, reg_rd,
                                                  wb_sel_ram, pc_load, flush, err_timeout}), 32'(12'h800));
      check($sformatf("midreset_retired%0d", i), 32'(retired), 32'd0);
    end
    reset = 1'b0;
    model_retired = 16'd0; model_err = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 32'({dec_ready, ram_req, reg_we, pc_load, flush}), 32'(5'b10000));

    // Wraparound of the retire counter from a preloaded value
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    model_retired = 16'hFFFE;
    check("preload", 32'(retired), 32'(16'hFFFE));
    for (int i = 0; i < 3; i++) run_instr(OP_NOP, 3'(i), 0, 0, 1'b0, 1'b1, 1'b0);
    check("wrap_final", 32'(retired), 32'(16'h0001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
